sent_tx_frame_gen: RTL and testbench

- Downstream stage of the SENT TX data register. Captures data_f1/data_f2 on its done strobe.
- Slices the captured data into data nibbles according to load_bit, computes the SAE J2716 CRC4, and drives the SENT line.
- Line sequence per frame: SYNC, STATUS, DATA×N, CRC, optional PAUSE.
- Holds one frame in a shadow buffer so consecutive frames go out back-to-back.

---
 rtl/sent_tx_frame_gen_if.sv | 27 ++
 rtl/sent_tx_frame_gen.sv | 197 +++++++++++++++++++
 tb/tb_sent_tx_frame_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sent_tx_frame_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// sent_tx_frame_gen_if : capture inputs and SENT line/status outputs
// Rev 1.0
//------------------------------------------------------------------------------
interface sent_tx_frame_gen_if;
   logic [2:0]  load_bit;
   logic [15:0] data_f1;
   logic [11:0] data_f2;
   logic        done;
   logic [3:0]  status_nibble;
   logic        sent_out;
   logic        frame_busy;
   logic        frame_done;
   logic        overrun;

   modport master (
      output load_bit, data_f1, data_f2, done, status_nibble,
      input  sent_out, frame_busy, frame_done, overrun
   );

   modport slave (
      input  load_bit, data_f1, data_f2, done, status_nibble,
      output sent_out, frame_busy, frame_done, overrun
   );
endinterface
`default_nettype wire

// File: rtl/sent_tx_frame_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// sent_tx_frame_gen : SENT frame generator (SYNC/STATUS/DATA/CRC/PAUSE) with shadow buffer
// Rev 1.0
//------------------------------------------------------------------------------
module sent_tx_frame_gen #(
   parameter int CLK_PER_TICK = 3,
   parameter int LOW_TICKS    = 5,
   parameter int PAUSE_TICKS  = 0
) (
   input wire                 clk_tx,
   input wire                 reset_tx,
   sent_tx_frame_gen_if.slave bus
);

   localparam int c_MAXT = (PAUSE_TICKS > 56) ? PAUSE_TICKS : 56;
   localparam int c_TW   = $clog2(c_MAXT + 1);
   localparam int c_PW   = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

   localparam logic [c_TW-1:0] c_SYNC_LEN  = c_TW'(56);
   localparam logic [c_TW-1:0] c_PAUSE_LEN = c_TW'(PAUSE_TICKS);
   localparam logic [c_TW-1:0] c_BASE_LEN  = c_TW'(12);
   localparam logic [c_TW-1:0] c_LOW       = c_TW'(LOW_TICKS);
   localparam logic [c_PW-1:0] c_PRE_LAST  = c_PW'(CLK_PER_TICK - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_STATUS, S_DATA, S_CRC, S_PAUSE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_cap_req, r_pending, r_overrun, r_frame_done, r_sent_out;
   logic [2:0]      r_sh_lb;
   logic [15:0]     r_sh_f1;
   logic [11:0]     r_sh_f2;
   logic [3:0]      r_sh_st;
   logic [23:0]     r_work;
   logic [2:0]      r_work_n, r_nib_idx;
   logic [3:0]      r_work_st, r_crc;
   logic [c_PW-1:0] r_pre, w_pre_nxt;
   logic [c_TW-1:0] r_tick, w_tick_nxt, w_len;
   logic            w_tick_last, w_last_nib, w_start, w_frame_end, w_bypass, w_sent_nxt;
   logic [2:0]      w_src_lb;
   logic [15:0]     w_src_f1;
   logic [11:0]     w_src_f2;
   logic [3:0]      w_src_st;

   // Multiply by x^4 modulo x^4+x^3+x^2+1
   function automatic logic [3:0] f_crc_t(input logic [3:0] v);
      logic [3:0] t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         t = {t[2:0], 1'b0} ^ (t[3] ? 4'hD : 4'h0);
      end
      return t;
   endfunction

   function automatic logic [23:0] f_map(input logic [2:0] lb, input logic [15:0] f1,
                                         input logic [11:0] f2);
      case (lb)
         3'b001:  return {f1[11:0], f2[3:0], f2[7:4], f2[11:8]};
         3'b010:  return {f1[11:0], 12'h000};
         3'b011:  return {f1, 8'h00};
         3'b100:  return {f1, f2[3:0], 4'h0};
         3'b110:  return {f1[13:0], f2[9:0]};
         default: return {f1, f2[7:0]};
      endcase
   endfunction

   function automatic logic [2:0] f_count(input logic [2:0] lb);
      case (lb)
         3'b010:  return 3'd3;
         3'b011:  return 3'd4;
         3'b100:  return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         S_STATUS: w_len = c_BASE_LEN + c_TW'(r_work_st);
         S_DATA:   w_len = c_BASE_LEN + c_TW'(r_work[23:20]);
         S_CRC:    w_len = c_BASE_LEN + c_TW'(r_crc);
         S_PAUSE:  w_len = c_PAUSE_LEN;
         default:  w_len = c_SYNC_LEN;
      endcase
      w_tick_last = (r_state != S_IDLE) && (r_pre == c_PRE_LAST) && (r_tick == w_len - c_TW'(1));
      w_last_nib  = (r_nib_idx == r_work_n - 3'd1);

      case (r_state)
         S_IDLE: if (r_pending) begin
            w_state_nxt = S_SYNC;
            w_start     = 1'b1;
         end
         S_SYNC:   if (w_tick_last) w_state_nxt = S_STATUS;
         S_STATUS: if (w_tick_last) w_state_nxt = S_DATA;
         S_DATA:   if (w_tick_last && w_last_nib) w_state_nxt = S_CRC;
         S_CRC: if (w_tick_last) begin
            if (PAUSE_TICKS != 0) w_state_nxt = S_PAUSE;
            else                  w_frame_end = 1'b1;
         end
         S_PAUSE: if (w_tick_last) w_frame_end = 1'b1;
         default: w_state_nxt = S_IDLE;
      endcase

      // A capture landing on the frame-end edge is forwarded straight into the next frame
      if (w_frame_end) begin
         if (r_pending || r_cap_req) begin
            w_state_nxt = S_SYNC;
            w_start     = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end
      w_bypass = w_frame_end & r_cap_req;
      w_src_lb = w_bypass ? bus.load_bit      : r_sh_lb;
      w_src_f1 = w_bypass ? bus.data_f1       : r_sh_f1;
      w_src_f2 = w_bypass ? bus.data_f2       : r_sh_f2;
      w_src_st = w_bypass ? bus.status_nibble : r_sh_st;

      if (w_state_nxt == S_IDLE || w_start || w_tick_last) begin
         w_pre_nxt  = '0;
         w_tick_nxt = '0;
      end else if (r_pre == c_PRE_LAST) begin
         w_pre_nxt  = '0;
         w_tick_nxt = r_tick + c_TW'(1);
      end else begin
         w_pre_nxt  = r_pre + c_PW'(1);
         w_tick_nxt = r_tick;
      end
      w_sent_nxt = (w_state_nxt == S_IDLE) ? 1'b1 : (w_tick_nxt >= c_LOW);
   end

   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         r_cap_req    <= 1'b0;
         r_pending    <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_done <= 1'b0;
         r_sent_out   <= 1'b1;
         r_pre        <= '0;
         r_tick       <= '0;
         r_sh_lb      <= 3'b000;
         r_sh_f1      <= 16'h0000;
         r_sh_f2      <= 12'h000;
         r_sh_st      <= 4'h0;
         r_work       <= 24'h000000;
         r_work_n     <= 3'd0;
         r_nib_idx    <= 3'd0;
         r_work_st    <= 4'h0;
         r_crc        <= 4'h5;
      end else begin
         r_cap_req    <= bus.done & (bus.load_bit != 3'b000);
         r_overrun    <= r_cap_req & r_pending & ~(w_start & ~w_bypass);
         r_frame_done <= w_frame_end;
         r_sent_out   <= w_sent_nxt;
         r_pre        <= w_pre_nxt;
         r_tick       <= w_tick_nxt;
         if (r_cap_req) begin
            r_sh_lb <= bus.load_bit;
            r_sh_f1 <= bus.data_f1;
            r_sh_f2 <= bus.data_f2;
            r_sh_st <= bus.status_nibble;
         end
         if (w_start) begin
            r_pending <= r_cap_req & ~w_bypass;
            r_work    <= f_map(w_src_lb, w_src_f1, w_src_f2);
            r_work_n  <= f_count(w_src_lb);
            r_work_st <= w_src_st;
            r_nib_idx <= 3'd0;
            r_crc     <= 4'h5;
         end else begin
            if (r_cap_req) r_pending <= 1'b1;
            if (r_state == S_DATA && w_tick_last) begin
               r_work    <= {r_work[19:0], 4'h0};
               r_nib_idx <= r_nib_idx + 3'd1;
               r_crc     <= w_last_nib ? f_crc_t(f_crc_t(r_crc) ^ r_work[23:20])
                                       : (f_crc_t(r_crc) ^ r_work[23:20]);
            end
         end
      end
   end

   assign bus.sent_out   = r_sent_out;
   assign bus.frame_busy = (r_state != S_IDLE);
   assign bus.frame_done = r_frame_done;
   assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sent_tx_frame_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_sent_tx_frame_gen : directed bench, element lengths measured on the SENT line
// Rev 1.0
//------------------------------------------------------------------------------
module tb_sent_tx_frame_gen;
   localparam int LOW = 5;

   logic clk_tx   = 1'b0;
   logic reset_tx = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   exp_t [9];

   always #5 clk_tx = ~clk_tx;

   sent_tx_frame_gen_if bus_a ();
   sent_tx_frame_gen_if bus_b ();

   sent_tx_frame_gen #(.CLK_PER_TICK(3), .LOW_TICKS(LOW), .PAUSE_TICKS(0)) dut_a (
      .clk_tx(clk_tx), .reset_tx(reset_tx), .bus(bus_a.slave));
   sent_tx_frame_gen #(.CLK_PER_TICK(2), .LOW_TICKS(LOW), .PAUSE_TICKS(20)) dut_b (
      .clk_tx(clk_tx), .reset_tx(reset_tx), .bus(bus_b.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic get_line(input int sel);
      return (sel != 0) ? bus_b.sent_out : bus_a.sent_out;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel != 0) ? bus_b.frame_done : bus_a.frame_done;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel != 0) ? bus_b.frame_busy : bus_a.frame_busy;
   endfunction

   task automatic pulse(input int sel, input logic [2:0] lb, input logic [15:0] f1,
                        input logic [11:0] f2, input logic [3:0] st);
      if (sel != 0) begin
         bus_b.load_bit = lb; bus_b.data_f1 = f1; bus_b.data_f2 = f2;
         bus_b.status_nibble = st; bus_b.done = 1'b1;
      end else begin
         bus_a.load_bit = lb; bus_a.data_f1 = f1; bus_a.data_f2 = f2;
         bus_a.status_nibble = st; bus_a.done = 1'b1;
      end
      @(negedge clk_tx);
      bus_a.done = 1'b0;
      bus_b.done = 1'b0;
   endtask

   // Measures n consecutive elements starting at the first low sample; exp_t holds ticks.
   task automatic check_frame(input int sel, input int n, input int cpt, input bit b2b,
                              input string tag);
      int guard, cnt, low;
      bit hi, prev, ended;
      guard = 0;
      while (get_line(sel) !== 1'b0 && guard < 3000) begin
         @(negedge clk_tx);
         guard++;
      end
      chk({tag, "_start"}, 32'(guard < 3000), 32'd1);
      for (int e = 0; e < n; e++) begin
         cnt = 0; low = 0; hi = 1'b0; ended = 1'b0;
         while (!ended && cnt < 3000) begin
            if (get_line(sel) === 1'b1) hi = 1'b1;
            else if (!hi)               low++;
            cnt++;
            prev = get_line(sel);
            @(negedge clk_tx);
            ended = (get_done(sel) === 1'b1) || (prev && get_line(sel) === 1'b0);
         end
         chk($sformatf("%s_e%0d_len", tag, e), 32'(cnt), 32'(exp_t[e] * cpt));
         chk($sformatf("%s_e%0d_low", tag, e), 32'(low), 32'(LOW * cpt));
         chk($sformatf("%s_e%0d_fdone", tag, e), 32'(get_done(sel)), 32'(e == n - 1));
      end
      chk({tag, "_line_end"}, 32'(get_line(sel)), b2b ? 32'd0 : 32'd1);
      chk({tag, "_busy_end"}, 32'(get_busy(sel)), 32'(b2b));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      bus_a.load_bit = 3'b000; bus_a.data_f1 = '0; bus_a.data_f2 = '0;
      bus_a.status_nibble = '0; bus_a.done = 1'b0;
      bus_b.load_bit = 3'b000; bus_b.data_f1 = '0; bus_b.data_f2 = '0;
      bus_b.status_nibble = '0; bus_b.done = 1'b0;

      repeat (3) @(negedge clk_tx);
      chk("rst_line_a", 32'(bus_a.sent_out), 32'd1);
      chk("rst_busy_a", 32'(bus_a.frame_busy), 32'd0);
      chk("rst_fdone_a", 32'(bus_a.frame_done), 32'd0);
      chk("rst_ovr_a", 32'(bus_a.overrun), 32'd0);
      chk("rst_line_b", 32'(bus_b.sent_out), 32'd1);
      chk("rst_busy_b", 32'(bus_b.frame_busy), 32'd0);
      reset_tx = 1'b0;
      @(negedge clk_tx);

      // load_bit 000 is ignored
      pulse(0, 3'b000, 16'hFFFF, 12'hFFF, 4'hF);
      bad = 0;
      repeat (30) begin
         @(negedge clk_tx);
         if (bus_a.sent_out !== 1'b1 || bus_a.frame_busy !== 1'b0) bad++;
      end
      chk("lb000_quiet", 32'(bad), 32'd0);

      // Format 010, all-zero data: CRC 9, SYNC low starts two edges after the strobe edge
      pulse(0, 3'b010, 16'h0000, 12'h000, 4'h0);
      chk("lat_k_line", 32'(bus_a.sent_out), 32'd1);
      @(negedge clk_tx);
      chk("lat_k1_line", 32'(bus_a.sent_out), 32'd1);
      chk("lat_k1_busy", 32'(bus_a.frame_busy), 32'd0);
      @(negedge clk_tx);
      chk("lat_k2_line", 32'(bus_a.sent_out), 32'd0);
      chk("lat_k2_busy", 32'(bus_a.frame_busy), 32'd1);
      exp_t = '{56, 12, 12, 12, 12, 21, 0, 0, 0};
      check_frame(0, 6, 3, 1'b0, "f010");
      @(negedge clk_tx);
      chk("f010_fdone_1cyc", 32'(bus_a.frame_done), 32'd0);
      chk("f010_idle_line", 32'(bus_a.sent_out), 32'd1);

      // Format 001: A,B,C,3,2,1 with status 7; CRC works out to 7
      pulse(0, 3'b001, 16'h0ABC, 12'h123, 4'h7);
      exp_t = '{56, 19, 22, 23, 24, 15, 14, 13, 19};
      check_frame(0, 9, 3, 1'b0, "f001");

      // Back-to-back: X running, Y queued, Z overwrites Y (overrun), Z follows X directly
      pulse(0, 3'b011, 16'h1234, 12'h000, 4'h1);
      exp_t = '{56, 13, 13, 14, 15, 16, 26, 0, 0};
      fork
         check_frame(0, 7, 3, 1'b1, "fX");
         begin
            repeat (30) @(negedge clk_tx);
            pulse(0, 3'b010, 16'h0FFF, 12'h000, 4'h2);
            @(negedge clk_tx);
            chk("ovr_y", 32'(bus_a.overrun), 32'd0);
            repeat (10) @(negedge clk_tx);
            pulse(0, 3'b100, 16'h0F0F, 12'h005, 4'h3);
            @(negedge clk_tx);
            chk("ovr_z", 32'(bus_a.overrun), 32'd1);
            @(negedge clk_tx);
            chk("ovr_z_clear", 32'(bus_a.overrun), 32'd0);
         end
      join
      exp_t = '{56, 15, 12, 27, 12, 27, 17, 21, 0};
      check_frame(0, 8, 3, 1'b0, "fZ");

      // Pause of 20 ticks on the second instance
      pulse(1, 3'b010, 16'h0000, 12'h000, 4'h0);
      exp_t = '{56, 12, 12, 12, 12, 21, 20, 0, 0};
      check_frame(1, 7, 2, 1'b0, "fpause");

      // Reset in the low phase of the first data element aborts the frame
      pulse(0, 3'b011, 16'hFFFF, 12'h000, 4'h0);
      repeat (2) @(negedge clk_tx);
      repeat (206) @(negedge clk_tx);
      chk("rst_mid_pre_line", 32'(bus_a.sent_out), 32'd0);
      chk("rst_mid_pre_busy", 32'(bus_a.frame_busy), 32'd1);
      #1 reset_tx = 1'b1;
      #1;
      chk("rst_mid_line", 32'(bus_a.sent_out), 32'd1);
      chk("rst_mid_busy", 32'(bus_a.frame_busy), 32'd0);
      bad = 0;
      repeat (3) begin
         @(negedge clk_tx);
         if (bus_a.frame_done !== 1'b0) bad++;
      end
      reset_tx = 1'b0;
      repeat (20) begin
         @(negedge clk_tx);
         if (bus_a.frame_done !== 1'b0 || bus_a.sent_out !== 1'b1 || bus_a.frame_busy !== 1'b0)
            bad++;
      end
      chk("rst_mid_quiet", 32'(bad), 32'd0);
      pulse(0, 3'b010, 16'h0000, 12'h000, 4'h0);
      exp_t = '{56, 12, 12, 12, 12, 21, 0, 0, 0};
      check_frame(0, 6, 3, 1'b0, "frestart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
